// File: rtl/imem_loader_if.sv
// imem_loader_if: start/config, word stream and byte-write port of the
// instruction memory loader. slave = the loader, master = the host side.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH-1:0] word_count;
   logic                  in_valid;
   logic [31:0]           in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [31:0]           checksum;

   modport slave (
      input  start, base_addr, word_count, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, checksum
   );

   modport master (
      output start, base_addr, word_count, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, checksum
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: accepts 32-bit instruction words and writes each as four
// big-endian byte writes (MSB at the lowest address) into byte-wide imem.
// Optional checksum accumulator: define IMEM_LOADER_CHECKSUM_EN.
// Every output is a flop; the *_d values are derived from the next state.
module imem_loader #(
   parameter int MEM_BYTES  = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, FINISH} state_t;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));
   localparam logic [ADDR_WIDTH:0]   MEM_END    = (ADDR_WIDTH+1)'(MEM_BYTES);

   state_t                state_q, state_d;
   logic [1:0]            beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]           word_q, word_d;        // bytes still to be written, MSB first
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]            mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q, mem_we_d;
   logic                  in_ready_q, in_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  overflow_q, overflow_d;

   logic                  handshake;
   logic [ADDR_WIDTH:0]   addr_inc;
   logic                  addr_wrap;
   logic [ADDR_WIDTH-1:0] addr_nxt;

   // in_ready_q is high exactly while in WAIT_WORD
   assign handshake = in_ready_q & bus.in_valid;
   assign addr_inc  = {1'b0, mem_addr_q} + (ADDR_WIDTH+1)'(1);
   assign addr_wrap = (addr_inc == MEM_END);
   assign addr_nxt  = addr_wrap ? '0 : addr_inc[ADDR_WIDTH-1:0];

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.start) state_d = (bus.word_count == '0) ? FINISH : WAIT_WORD;
         WAIT_WORD: if (handshake) state_d = WRITE;
         WRITE:     if (beat_q == 2'd3) state_d = (cnt_q == '0) ? FINISH : WAIT_WORD;
         FINISH:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // output and datapath next values; outputs are registered from state_d
   always_comb begin
      beat_d      = beat_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      overflow_d  = overflow_q;
      in_ready_d  = (state_d == WAIT_WORD);
      mem_we_d    = (state_d == WRITE);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FINISH);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d      = bus.word_count;
               mem_addr_d = bus.base_addr & ALIGN_MASK;
               overflow_d = 1'b0;
            end
         end
         WAIT_WORD: begin
            if (handshake) begin
               cnt_d       = cnt_q - ADDR_WIDTH'(1);
               beat_d      = 2'd0;
               mem_wdata_d = bus.in_data[31:24];
               word_d      = {bus.in_data[23:0], 8'h00};
            end
         end
         WRITE: begin
            // advance to the next byte; after beat 3 the address already
            // points at the first byte of the following word
            beat_d      = beat_q + 2'd1;
            mem_wdata_d = word_q[31:24];
            word_d      = {word_q[23:0], 8'h00};
            mem_addr_d  = addr_nxt;
            if (addr_wrap) overflow_d = 1'b1;
         end
         default: ;
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_q      <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   // XOR of every accepted word, cleared by an accepted start
   always_comb begin
      checksum_d = checksum_q;
      if (state_q == IDLE && bus.start) checksum_d = '0;
      else if (handshake)               checksum_d = checksum_q ^ bus.in_data;
   end

   // checksum register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) checksum_q <= '0;
      else       checksum_q <= checksum_d;
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = '0;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a
// reference model of the byte stream, overflow and checksum.
module tb_imem_loader;
   localparam int MEM_BYTES = 16;
   localparam int AW        = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  wq_a[$];
   logic [7:0]  wq_d[$];
   int          done_cnt;
   logic [31:0] wbuf[16];

   // memory-side view: a byte is committed on the rising edge while mem_we is high
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wq_a.push_back(bus.mem_addr);
         wq_d.push_back(bus.mem_wdata);
      end
      if (bus.done === 1'b1) done_cnt++;
   end

   // one complete load with timing, byte-stream, overflow and checksum checks
   task automatic run_load(input logic [7:0] base, input int n, input int max_gap,
                           input bit withhold, input string tag);
      logic [7:0]  exp_a[$];
      logic [7:0]  exp_d[$];
      logic [31:0] exp_ck;
      bit          hit_top;
      int          bidx;
      bit          qbad;
      exp_ck  = '0;
      hit_top = 1'b0;
      bidx    = 0;
      for (int i = 0; i < n; i++) begin
         exp_ck ^= wbuf[i];
         for (int k = 0; k < 4; k++) begin
            exp_a.push_back(8'((int'(base & 8'hFC) + 4 * i + k) % MEM_BYTES));
            exp_d.push_back(8'(wbuf[i] >> (24 - 8 * k)));
         end
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      exp_ck = '0;
`endif
      wq_a.delete();
      wq_d.delete();
      done_cnt = 0;

      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.word_count = 8'(n);
      @(posedge clk);
      #1;
      bus.start      = 1'b0;
      bus.base_addr  = 8'($urandom);
      bus.word_count = 8'($urandom);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== (n != 0) || bus.done !== (n == 0) ||
          bus.overflow !== 1'b0 || bus.checksum !== 32'h0 || bus.mem_we !== 1'b0)
         $display("FAIL %s start_resp busy=%b rdy=%b done=%b ov=%b ck=%h we=%b exp busy=1 rdy=%b done=%b ov=0 ck=0 we=0",
                  tag, bus.busy, bus.in_ready, bus.done, bus.overflow, bus.checksum, bus.mem_we, n != 0, n == 0);
      if (bus.busy !== 1'b1 || bus.in_ready !== (n != 0) || bus.done !== (n == 0) ||
          bus.overflow !== 1'b0 || bus.checksum !== 32'h0 || bus.mem_we !== 1'b0) errors++;

      for (int i = 0; i < n; i++) begin
         int gap;
         gap = (withhold && i == 0) ? 10 : int'($urandom_range(max_gap, 0));
         for (int g = 0; g < gap; g++) begin
            if (withhold && i == 0 && g == 4) begin
               bus.start      = 1'b1;
               bus.base_addr  = 8'h08;
               bus.word_count = 8'h07;
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL %s wait_word rdy=%b we=%b busy=%b exp 1 0 1", tag, bus.in_ready, bus.mem_we, bus.busy);
            end
         end
         bus.start    = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_data  = wbuf[i];
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.in_data  = $urandom;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_we !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.mem_addr !== exp_a[bidx] || bus.mem_wdata !== exp_d[bidx] || bus.overflow !== hit_top) begin
               errors++;
               $display("FAIL %s beat w%0d b%0d we=%b rdy=%b busy=%b addr=%h data=%h ov=%b exp we=1 rdy=0 busy=1 addr=%h data=%h ov=%b",
                        tag, i, k, bus.mem_we, bus.in_ready, bus.busy, bus.mem_addr, bus.mem_wdata, bus.overflow,
                        exp_a[bidx], exp_d[bidx], hit_top);
            end
            if (exp_a[bidx] == 8'(MEM_BYTES - 1)) hit_top = 1'b1;
            bidx++;
         end
         @(negedge clk);
         checks++;
         if (i < n - 1) begin
            if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL %s next_word rdy=%b we=%b busy=%b done=%b exp 1 0 1 0", tag, bus.in_ready, bus.mem_we, bus.busy, bus.done);
            end
         end else begin
            if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s finish done=%b busy=%b we=%b rdy=%b exp 1 1 0 0", tag, bus.done, bus.busy, bus.mem_we, bus.in_ready);
            end
         end
      end

      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
         errors++;
         $display("FAIL %s idle busy=%b done=%b rdy=%b we=%b exp 0 0 0 0", tag, bus.busy, bus.done, bus.in_ready, bus.mem_we);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s done_pulses got=%0d exp=1", tag, done_cnt);
      end
      checks++;
      if (bus.overflow !== hit_top) begin
         errors++;
         $display("FAIL %s overflow got=%b exp=%b", tag, bus.overflow, hit_top);
      end
      checks++;
      if (bus.checksum !== exp_ck) begin
         errors++;
         $display("FAIL %s checksum got=%h exp=%h", tag, bus.checksum, exp_ck);
      end
      qbad = (wq_a.size() != exp_a.size());
      if (!qbad)
         for (int j = 0; j < exp_a.size(); j++)
            if (wq_a[j] !== exp_a[j] || wq_d[j] !== exp_d[j]) qbad = 1'b1;
      checks++;
      if (qbad) begin
         errors++;
         $display("FAIL %s committed_bytes got=%0d writes exp=%0d writes (or addr/data differ)", tag, wq_a.size(), exp_a.size());
      end
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.word_count = '0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h0 || bus.mem_wdata !== 8'h0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0 || bus.checksum !== 32'h0) begin
         errors++;
         $display("FAIL reset_values rdy=%b we=%b addr=%h data=%h busy=%b done=%b ov=%b ck=%h exp all 0",
                  bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.overflow, bus.checksum);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release busy=%b rdy=%b exp 0 0", bus.busy, bus.in_ready);
      end
   endtask

   task automatic test_basic();
      wbuf[0] = 32'h8C080004;
      wbuf[1] = 32'h01095020;
      run_load(8'h00, 2, 2, 1'b0, "basic");
   endtask

   task automatic test_align();
      wbuf[0] = 32'hAABBCCDD;
      run_load(8'h06, 1, 1, 1'b0, "align");
   endtask

   task automatic test_wrap();
      wbuf[0] = 32'h11223344;
      wbuf[1] = 32'h55667788;
      run_load(8'd12, 2, 1, 1'b0, "wrap");
   endtask

   task automatic test_withhold();
      wbuf[0] = 32'hCAFEF00D;
      run_load(8'h04, 1, 0, 1'b1, "withhold");
   endtask

   task automatic test_zero_count();
      run_load(8'h08, 0, 0, 1'b0, "zero_count");
   endtask

   task automatic test_reset_mid();
      wq_a.delete();
      wq_d.delete();
      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = 8'h00;
      bus.word_count = 8'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h12345678;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);     // third beat (byte 0x56) is now presented
      reset = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h0 || bus.mem_wdata !== 8'h0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0 || bus.checksum !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs rdy=%b we=%b addr=%h data=%h busy=%b done=%b ov=%b ck=%h exp all 0",
                  bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.overflow, bus.checksum);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (wq_a.size() != 2 || wq_a[0] !== 8'h00 || wq_d[0] !== 8'h12 || wq_a[1] !== 8'h01 || wq_d[1] !== 8'h34) begin
         errors++;
         $display("FAIL reset_mid_bytes got=%0d writes exp=2 writes 12@00 34@01", wq_a.size());
      end
      wbuf[0] = 32'hDEADBEEF;
      wbuf[1] = 32'h0BADF00D;
      run_load(8'h04, 2, 1, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         int          n;
         logic [7:0]  base;
         n    = int'($urandom_range(4, 0));
         base = 8'($urandom_range(MEM_BYTES - 1, 0));
         for (int i = 0; i < n; i++) wbuf[i] = $urandom;
         run_load(base, n, 3, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_align();
      test_wrap();
      test_withhold();
      test_zero_count();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
